// File: rtl/rca_pkg.sv
// Shared constants and FSM state type for the
// byte-serial ripple-carry add/subtract controller.
package rca_pkg;

   localparam int BYTE_W      = 8;
   localparam int NBYTES_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/rca8bit.sv
// 8-bit ripple-carry adder: a chain of full adders
// from bit 0 upward, carry-in C, carry-out cout.
module rca8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       C,
   output logic [7:0] S,
   output logic       cout
);

   // ripple the carry through eight full-adder cells
   always_comb begin
      logic c;
      c = C;
      S = '0;
      for (int i = 0; i < 8; i++) begin
         S[i] = A[i] ^ B[i] ^ c;
         c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/rca_seq_ctrl.sv
// Byte-serial add/subtract: one shared 8-bit adder
// walks the operands a slice per cycle.
module rca_seq_ctrl
   import rca_pkg::*;
#(
   parameter int NBYTES = NBYTES_DFLT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] op_a,
   input  logic [BYTE_W*NBYTES-1:0] op_b,
   input  logic                     sub,
   input  logic                     cin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     cout,
   output logic                     ovf
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] KLAST = KW'(NBYTES - 1);

   state_t state, nxt;

   logic [KW-1:0]     k;
   logic [W-1:0]      a_q;
   logic [W-1:0]      b_q;
   logic [W-1:0]      res_q;
   logic              carry;
   logic [BYTE_W-1:0] a_sl;
   logic [BYTE_W-1:0] b_sl;
   logic [BYTE_W-1:0] s_sl;
   logic              c_out;
   logic              acc;
   logic              last;

   assign acc  = in_valid && (state == IDLE);
   assign last = (k == KLAST);

   assign a_sl = a_q[k*BYTE_W +: BYTE_W];
   assign b_sl = b_q[k*BYTE_W +: BYTE_W];

   rca8bit u_add (
      .A    (a_sl),
      .B    (b_sl),
      .C    (carry),
      .S    (s_sl),
      .cout (c_out)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // next state and handshake outputs
   always_comb begin
      nxt       = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) nxt = RUN;
         end
         RUN: begin
            if (last) nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // operand latch on accept, one slice per RUN cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         carry <= 1'b0;
         k     <= '0;
      end else if (acc) begin
         a_q   <= op_a;
         b_q   <= sub ? ~op_b : op_b;
         carry <= sub | cin;
         k     <= '0;
      end else if (state == RUN) begin
         res_q[k*BYTE_W +: BYTE_W] <= s_sl;
         carry <= c_out;
         k     <= last ? '0 : k + 1'b1;
      end
   end

   assign result = res_q;
   assign cout   = carry;
   assign ovf    = (a_q[W-1] == b_q[W-1]) &&
                   (res_q[W-1] != a_q[W-1]);

endmodule
